// File: rtl/tcdm_traffic_gen_if.sv
// TCDM master/slave bus bundle used by the traffic generator.
// Signal names keep the master-side view: *_o driven by the master, *_i by the slave.
interface tcdm_traffic_gen_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned AUX_WIDTH  = 5
);
    logic                  data_req_o;
    logic                  data_gnt_i;
    logic [ADDR_WIDTH-1:0] data_add_o;
    logic                  data_wen_o;
    logic [DATA_WIDTH-1:0] data_wdata_o;
    logic [BE_WIDTH-1:0]   data_be_o;
    logic [AUX_WIDTH-1:0]  data_aux_o;
    logic                  data_r_valid_i;
    logic [DATA_WIDTH-1:0] data_r_rdata_i;
    logic [AUX_WIDTH-1:0]  data_r_aux_i;
    logic                  data_err_i;

    modport master (
        output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_aux_o,
        input  data_gnt_i, data_r_valid_i, data_r_rdata_i, data_r_aux_i, data_err_i
    );

    modport slave (
        input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_aux_o,
        output data_gnt_i, data_r_valid_i, data_r_rdata_i, data_r_aux_i, data_err_i
    );
endinterface

// File: rtl/tcdm_traffic_gen.sv
// TCDM master traffic generator: write, read or write-then-verify bursts over an
// incrementing address window, with in-order response tracking and saturating status counters.
module tcdm_traffic_gen #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned AUX_WIDTH       = 5,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] SEED            = 32'hA5A5_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  num_trans_i,
    tcdm_traffic_gen_if.master    bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic [CNT_WIDTH-1:0]  mismatch_cnt_o
);

    localparam int unsigned OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_WIDTH-1:0]  OUT_MAX = OUT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [OUT_WIDTH-1:0]  OUT_ONE = OUT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1'b1);
    localparam logic [DATA_WIDTH-1:0] SEED_D  = DATA_WIDTH'(SEED);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pattern_of(input logic [CNT_WIDTH-1:0] i);
        return SEED_D ^ DATA_WIDTH'(i);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] b,
                                                      input logic [CNT_WIDTH-1:0]  i);
        return b + ADDR_WIDTH'(i) * ADDR_WIDTH'(BE_WIDTH);
    endfunction

    state_e                state_r, state_s;
    logic                  wtr_r, wtr_s;
    logic [ADDR_WIDTH-1:0] base_r, base_s;
    logic [CNT_WIDTH-1:0]  num_r, num_s;
    logic [CNT_WIDTH-1:0]  idx_r, idx_s;
    logic [CNT_WIDTH-1:0]  rsp_idx_r, rsp_idx_s;
    logic [OUT_WIDTH-1:0]  out_r, out_s;
    logic [CNT_WIDTH-1:0]  err_cnt_r, err_cnt_s;
    logic [CNT_WIDTH-1:0]  mis_cnt_r, mis_cnt_s;
    logic                  req_r, req_s;
    logic [ADDR_WIDTH-1:0] add_r, add_s;
    logic                  wen_r, wen_s;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
    logic [BE_WIDTH-1:0]   be_r, be_s;
    logic [AUX_WIDTH-1:0]  aux_r, aux_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;

    logic active_s;
    logic fire_s;
    logic rsp_s;
    logic phase_done_s;
    logic rsp_bad_s;
    logic issue_s;

    assign active_s     = (state_r == ST_WRITE) || (state_r == ST_READ);
    assign fire_s       = req_r & bus.data_gnt_i;
    // Responses with nothing in flight (e.g. stragglers after a reset) are dropped.
    assign rsp_s        = bus.data_r_valid_i && (out_r != {OUT_WIDTH{1'b0}}) && active_s;
    assign phase_done_s = (idx_r == num_r) && (out_r == {OUT_WIDTH{1'b0}});
    assign rsp_bad_s    = (bus.data_r_rdata_i != pattern_of(rsp_idx_r)) ||
                          (bus.data_r_aux_i != AUX_WIDTH'(rsp_idx_r));

    // Next-state, counters and the registered request image.
    always_comb begin
        state_s   = state_r;
        wtr_s     = wtr_r;
        base_s    = base_r;
        num_s     = num_r;
        idx_s     = idx_r;
        rsp_idx_s = rsp_idx_r;
        out_s     = out_r;
        err_cnt_s = err_cnt_r;
        mis_cnt_s = mis_cnt_r;
        req_s     = 1'b0;
        add_s     = {ADDR_WIDTH{1'b0}};
        wen_s     = 1'b0;
        wdata_s   = {DATA_WIDTH{1'b0}};
        be_s      = {BE_WIDTH{1'b0}};
        aux_s     = {AUX_WIDTH{1'b0}};
        issue_s   = 1'b0;

        if (fire_s) begin
            idx_s = idx_r + CNT_ONE;
        end else begin
            idx_s = idx_r;
        end

        case ({fire_s, rsp_s})
            2'b10:   out_s = out_r + OUT_ONE;
            2'b01:   out_s = out_r - OUT_ONE;
            default: out_s = out_r;
        endcase

        if (rsp_s) begin
            rsp_idx_s = rsp_idx_r + CNT_ONE;
            if (bus.data_err_i) begin
                err_cnt_s = sat_inc(err_cnt_r);
            end else begin
                err_cnt_s = err_cnt_r;
            end
            if ((state_r == ST_READ) && rsp_bad_s) begin
                mis_cnt_s = sat_inc(mis_cnt_r);
            end else begin
                mis_cnt_s = mis_cnt_r;
            end
        end else begin
            rsp_idx_s = rsp_idx_r;
        end

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    wtr_s     = (mode_i == 2'd2);
                    base_s    = base_addr_i;
                    num_s     = num_trans_i;
                    idx_s     = {CNT_WIDTH{1'b0}};
                    rsp_idx_s = {CNT_WIDTH{1'b0}};
                    out_s     = {OUT_WIDTH{1'b0}};
                    err_cnt_s = {CNT_WIDTH{1'b0}};
                    mis_cnt_s = {CNT_WIDTH{1'b0}};
                    state_s   = (mode_i == 2'd1) ? ST_READ : ST_WRITE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WRITE: begin
                // An empty burst skips the read phase so DONE still lands within two cycles.
                if (phase_done_s) begin
                    if (wtr_r && (num_r != {CNT_WIDTH{1'b0}})) begin
                        state_s   = ST_READ;
                        idx_s     = {CNT_WIDTH{1'b0}};
                        rsp_idx_s = {CNT_WIDTH{1'b0}};
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (phase_done_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_READ;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        // Request is computed from next-cycle idx/outstanding so it can be registered.
        issue_s = (state_s == state_r) && active_s && (idx_s < num_r) && (out_s < OUT_MAX);

        if (issue_s) begin
            req_s = 1'b1;
            add_s = addr_of(base_r, idx_s);
            aux_s = AUX_WIDTH'(idx_s);
            if (state_r == ST_WRITE) begin
                wen_s   = 1'b0;
                wdata_s = pattern_of(idx_s);
                be_s    = {BE_WIDTH{1'b1}};
            end else begin
                wen_s   = 1'b1;
                wdata_s = {DATA_WIDTH{1'b0}};
                be_s    = {BE_WIDTH{1'b0}};
            end
        end else begin
            req_s = 1'b0;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            wtr_r     <= 1'b0;
            base_r    <= {ADDR_WIDTH{1'b0}};
            num_r     <= {CNT_WIDTH{1'b0}};
            idx_r     <= {CNT_WIDTH{1'b0}};
            rsp_idx_r <= {CNT_WIDTH{1'b0}};
            out_r     <= {OUT_WIDTH{1'b0}};
            err_cnt_r <= {CNT_WIDTH{1'b0}};
            mis_cnt_r <= {CNT_WIDTH{1'b0}};
            req_r     <= 1'b0;
            add_r     <= {ADDR_WIDTH{1'b0}};
            wen_r     <= 1'b0;
            wdata_r   <= {DATA_WIDTH{1'b0}};
            be_r      <= {BE_WIDTH{1'b0}};
            aux_r     <= {AUX_WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            wtr_r     <= wtr_s;
            base_r    <= base_s;
            num_r     <= num_s;
            idx_r     <= idx_s;
            rsp_idx_r <= rsp_idx_s;
            out_r     <= out_s;
            err_cnt_r <= err_cnt_s;
            mis_cnt_r <= mis_cnt_s;
            req_r     <= req_s;
            add_r     <= add_s;
            wen_r     <= wen_s;
            wdata_r   <= wdata_s;
            be_r      <= be_s;
            aux_r     <= aux_s;
            busy_r    <= (state_s == ST_WRITE) || (state_s == ST_READ);
            done_r    <= (state_s == ST_DONE);
        end
    end

    assign bus.data_req_o   = req_r;
    assign bus.data_add_o   = add_r;
    assign bus.data_wen_o   = wen_r;
    assign bus.data_wdata_o = wdata_r;
    assign bus.data_be_o    = be_r;
    assign bus.data_aux_o   = aux_r;
    assign busy_o           = busy_r;
    assign done_o           = done_r;
    assign err_cnt_o        = err_cnt_r;
    assign mismatch_cnt_o   = mis_cnt_r;

endmodule
